// File: rtl/sim_exit_monitor.sv
// Simulation completion monitor: settles on one verdict (pass, fail code, timeout) and raises done after a drain window.
// Optional progress-silence detection is built when SIM_EXIT_MONITOR_HANG_DETECT_EN is defined.
module sim_exit_monitor #(
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES = 10,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned HANG_CYCLES  = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        success,
  input  logic        exit_valid,
  input  logic [31:0] exit_code,
  output logic        exit_ready,
  input  logic        progress,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_code,
  output logic        timed_out,
  output logic [63:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [31:0] CODE_TIMEOUT = 32'hFFFF_FFFF;
  localparam logic [31:0] CODE_HANG    = 32'hFFFF_FFFE;

  state_t      state;
  state_t      state_next;
  logic [7:0]  drain_cnt;
  logic        ready_next;
  logic        done_next;

  logic        ev_exit;
  logic        ev_success;
  logic        ev_watchdog;
  logic        ev_hang;
  logic        verdict_hit;
  logic        verdict_pass;
  logic        verdict_timeout;
  logic [31:0] verdict_code;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (cycle_count != '1) begin
      cycle_count <= cycle_count + 64'd1;
    end
  end

  assign ev_exit     = (state == ST_RUN) && exit_valid;
  assign ev_success  = (state == ST_RUN) && success;
  assign ev_watchdog = (state == ST_RUN) && (MAX_CYCLES != 0) &&
                       (cycle_count == 64'(MAX_CYCLES));

`ifdef SIM_EXIT_MONITOR_HANG_DETECT_EN
  logic [31:0] silence;

  // Cleared while blanking so it starts from zero on entry to RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      silence <= '0;
    end else if (state != ST_RUN) begin
      silence <= '0;
    end else if (progress) begin
      silence <= '0;
    end else if (silence != '1) begin
      silence <= silence + 32'd1;
    end
  end

  assign ev_hang = (state == ST_RUN) && (silence == 32'(HANG_CYCLES));
`else
  logic unused_progress;

  assign unused_progress = progress;
  assign ev_hang         = 1'b0;
`endif

  always_comb begin
    verdict_hit     = 1'b0;
    verdict_pass    = 1'b0;
    verdict_timeout = 1'b0;
    verdict_code    = '0;
    if (ev_exit) begin
      verdict_hit  = 1'b1;
      verdict_pass = (exit_code == 32'd0);
      verdict_code = exit_code;
    end else if (ev_success) begin
      verdict_hit  = 1'b1;
      verdict_pass = 1'b1;
    end else if (ev_watchdog) begin
      verdict_hit     = 1'b1;
      verdict_timeout = 1'b1;
      verdict_code    = CODE_TIMEOUT;
    end else if (ev_hang) begin
      verdict_hit  = 1'b1;
      verdict_code = CODE_HANG;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_BLANK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_BLANK: if (cycle_count == 64'(BLANK_CYCLES)) state_next = ST_RUN;
      ST_RUN:   if (verdict_hit) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 8'd0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_BLANK;
    endcase
  end

  // Decoded from the next state so exit_ready and done come straight off flops.
  always_comb begin
    ready_next = 1'b0;
    done_next  = 1'b0;
    unique case (state_next)
      ST_RUN:  ready_next = 1'b1;
      ST_DONE: done_next  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exit_ready <= 1'b0;
      done       <= 1'b0;
    end else begin
      exit_ready <= ready_next;
      done       <= done_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
    end else if ((state == ST_RUN) && verdict_hit) begin
      drain_cnt <= 8'(DRAIN_CYCLES - 1);
    end else if ((state == ST_DRAIN) && (drain_cnt != 8'd0)) begin
      drain_cnt <= drain_cnt - 8'd1;
    end
  end

  // Only the winning event writes the verdict, and only once per reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass      <= 1'b0;
      fail_code <= '0;
      timed_out <= 1'b0;
    end else if ((state == ST_RUN) && verdict_hit) begin
      pass      <= verdict_pass;
      fail_code <= verdict_pass ? 32'd0 : verdict_code;
      timed_out <= verdict_timeout;
    end
  end

endmodule
